// File: rtl/hilo_acc_reg.sv
// rtl/hilo_acc_reg.sv - HI/LO register pair with per-half writes and two-cycle MADD/MSUB
// Define HILO_ACC_EN to build in the accumulate FSM; without it the block is a plain HI/LO pair.
module hilo_acc_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [2:0]            op_mode_i,
    input  logic [DATA_WIDTH-1:0] hi_input_i,
    input  logic [DATA_WIDTH-1:0] lo_input_i,
    output logic [DATA_WIDTH-1:0] hi_output_o,
    output logic [DATA_WIDTH-1:0] lo_output_o,
    output logic                  hilo_stable_o,
    output logic                  acc_done_o
);
    localparam logic [2:0] MODE_WRITE_HI   = 3'b001;
    localparam logic [2:0] MODE_WRITE_LO   = 3'b010;
    localparam logic [2:0] MODE_WRITE_BOTH = 3'b011;

    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] hi_d;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [DATA_WIDTH-1:0] lo_d;
    logic                  accept;
    logic                  wr_hi;
    logic                  wr_lo;

    assign accept = op_valid_i && op_ready_o;
    assign wr_hi  = accept && ((op_mode_i == MODE_WRITE_HI) || (op_mode_i == MODE_WRITE_BOTH));
    assign wr_lo  = accept && ((op_mode_i == MODE_WRITE_LO) || (op_mode_i == MODE_WRITE_BOTH));

    assign hi_output_o = hi_q;
    assign lo_output_o = lo_q;

`ifdef HILO_ACC_EN
    localparam logic [2:0] MODE_MADD = 3'b100;
    localparam logic [2:0] MODE_MSUB = 3'b101;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACC_HI = 1'b1
    } state_t;

    state_t                state_q;
    logic                  carry_q;
    logic                  sub_q;
    logic                  acc_done_q;
    logic [DATA_WIDTH-1:0] hi_op_q;
    logic                  start_madd;
    logic                  start_msub;
    logic [DATA_WIDTH:0]   lo_sum;
    logic [DATA_WIDTH:0]   lo_diff;
    logic [DATA_WIDTH-1:0] carry_ext;

    assign op_ready_o    = (state_q == ST_IDLE);
    assign hilo_stable_o = (state_q == ST_IDLE);
    assign acc_done_o    = acc_done_q;

    assign start_madd = accept && (op_mode_i == MODE_MADD);
    assign start_msub = accept && (op_mode_i == MODE_MSUB);

    // Top bit of the widened difference is set exactly when LO borrows.
    assign lo_sum    = {1'b0, lo_q} + {1'b0, lo_input_i};
    assign lo_diff   = {1'b0, lo_q} - {1'b0, lo_input_i};
    assign carry_ext = {{(DATA_WIDTH-1){1'b0}}, carry_q};

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wr_hi) hi_d = hi_input_i;
        if (wr_lo) lo_d = lo_input_i;
        if (start_madd) lo_d = lo_sum[DATA_WIDTH-1:0];
        if (start_msub) lo_d = lo_diff[DATA_WIDTH-1:0];
        if (state_q == ST_ACC_HI) begin
            hi_d = sub_q ? (hi_q - hi_op_q - carry_ext) : (hi_q + hi_op_q + carry_ext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            carry_q    <= 1'b0;
            sub_q      <= 1'b0;
            hi_op_q    <= '0;
            acc_done_q <= 1'b0;
        end else begin
            acc_done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (start_madd || start_msub) begin
                    carry_q <= start_msub ? lo_diff[DATA_WIDTH] : lo_sum[DATA_WIDTH];
                    hi_op_q <= hi_input_i;
                    sub_q   <= start_msub;
                    state_q <= ST_ACC_HI;
                end
            end else begin
                acc_done_q <= 1'b1;
                state_q    <= ST_IDLE;
            end
        end
    end
`else
    assign op_ready_o    = 1'b1;
    assign hilo_stable_o = 1'b1;
    assign acc_done_o    = 1'b0;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wr_hi) hi_d = hi_input_i;
        if (wr_lo) lo_d = lo_input_i;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: tb/tb_hilo_acc_reg.sv
// tb/tb_hilo_acc_reg.sv - randomized self-checking bench for hilo_acc_reg
// Expected values come from a {HI,LO} arithmetic model; accumulate checks follow HILO_ACC_EN.
module tb_hilo_acc_reg;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_mode;
    logic [DW-1:0] hi_in;
    logic [DW-1:0] lo_in;
    logic [DW-1:0] hi_out;
    logic [DW-1:0] lo_out;
    logic          hilo_stable;
    logic          acc_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*DW-1:0] m_acc;

    hilo_acc_reg #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid_i   (op_valid),
        .op_ready_o   (op_ready),
        .op_mode_i    (op_mode),
        .hi_input_i   (hi_in),
        .lo_input_i   (lo_in),
        .hi_output_o  (hi_out),
        .lo_output_o  (lo_out),
        .hilo_stable_o(hilo_stable),
        .acc_done_o   (acc_done)
    );

    always #5 clk = ~clk;

    task automatic do_op(input logic [2:0] mode, input logic [DW-1:0] h, input logic [DW-1:0] l);
        op_valid = 1'b1;
        op_mode  = mode;
        hi_in    = h;
        lo_in    = l;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_mode  = 3'($urandom);
        hi_in    = $urandom;
        lo_in    = $urandom;
    endtask

    function automatic logic [2*DW-1:0] write_model(input logic [2*DW-1:0] cur, input logic [2:0] mode,
                                                    input logic [DW-1:0] h, input logic [DW-1:0] l);
        logic [DW-1:0] nh;
        logic [DW-1:0] nl;
        nh = cur[2*DW-1:DW];
        nl = cur[DW-1:0];
        if (mode == 3'd1 || mode == 3'd3) nh = h;
        if (mode == 3'd2 || mode == 3'd3) nl = l;
        return {nh, nl};
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_mode  = 3'd0;
        hi_in    = '0;
        lo_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        m_acc = '0;
        n_checks++; if ({hi_out, lo_out} !== m_acc) begin n_fail++; $display("FAIL reset_hilo got %h want %h", {hi_out, lo_out}, m_acc); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", op_ready); end
        n_checks++; if (hilo_stable !== 1'b1) begin n_fail++; $display("FAIL reset_stable got %b want 1", hilo_stable); end
        n_checks++; if (acc_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", acc_done); end
        rst_n = 1'b1;
    endtask

    task automatic test_writes();
        do_op(3'd3, 32'h12345678, 32'h9ABCDEF0);
        n_checks++; if (hi_out !== 32'h12345678) begin n_fail++; $display("FAIL wboth_hi got %h want 12345678", hi_out); end
        n_checks++; if (lo_out !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL wboth_lo got %h want 9abcdef0", lo_out); end
        do_op(3'd1, 32'hAAAAAAAA, 32'h0);
        n_checks++; if (hi_out !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL whi_hi got %h want aaaaaaaa", hi_out); end
        n_checks++; if (lo_out !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL whi_lo got %h want 9abcdef0", lo_out); end
        m_acc = {32'hAAAAAAAA, 32'h9ABCDEF0};
    endtask

    task automatic test_back_to_back();
        logic [2:0]    mode;
        logic [DW-1:0] h;
        logic [DW-1:0] l;
        for (int i = 0; i < 40; i++) begin
            mode = 3'($urandom_range(0, 7));
            if (mode == 3'd4 || mode == 3'd5) mode = 3'($urandom_range(0, 3));
            h = $urandom;
            l = $urandom;
            do_op(mode, h, l);
            m_acc = write_model(m_acc, mode, h, l);
            n_checks++; if ({hi_out, lo_out} !== m_acc) begin n_fail++; $display("FAIL b2b_write[%0d] mode %0d got %h want %h", i, mode, {hi_out, lo_out}, m_acc); end
            n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", i, op_ready); end
        end
    endtask

`ifdef HILO_ACC_EN
    task automatic test_madd_carry();
        do_op(3'd3, 32'h0, 32'hFFFFFFFF);
        do_op(3'd4, 32'h0, 32'h1);
        n_checks++; if (lo_out !== 32'h0) begin n_fail++; $display("FAIL madd_e1_lo got %h want 0", lo_out); end
        n_checks++; if (hi_out !== 32'h0) begin n_fail++; $display("FAIL madd_e1_hi got %h want 0", hi_out); end
        n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL madd_e1_ready got %b want 0", op_ready); end
        n_checks++; if (hilo_stable !== 1'b0) begin n_fail++; $display("FAIL madd_e1_stable got %b want 0", hilo_stable); end
        n_checks++; if (acc_done !== 1'b0) begin n_fail++; $display("FAIL madd_e1_done got %b want 0", acc_done); end
        @(posedge clk); #1;
        n_checks++; if (hi_out !== 32'h1) begin n_fail++; $display("FAIL madd_e2_hi got %h want 1", hi_out); end
        n_checks++; if (acc_done !== 1'b1) begin n_fail++; $display("FAIL madd_e2_done got %b want 1", acc_done); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL madd_e2_ready got %b want 1", op_ready); end
        @(posedge clk); #1;
        n_checks++; if (acc_done !== 1'b0) begin n_fail++; $display("FAIL madd_done_pulse got %b want 0", acc_done); end
        m_acc = {32'h1, 32'h0};
    endtask

    task automatic test_msub_wrap();
        do_op(3'd3, 32'h0, 32'h0);
        do_op(3'd5, 32'h0, 32'h1);
        n_checks++; if (lo_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL msub_e1_lo got %h want ffffffff", lo_out); end
        @(posedge clk); #1;
        n_checks++; if ({hi_out, lo_out} !== 64'hFFFFFFFF_FFFFFFFF) begin n_fail++; $display("FAIL msub_final got %h want ffffffffffffffff", {hi_out, lo_out}); end
        do_op(3'd4, 32'h0, 32'h1);
        @(posedge clk); #1;
        n_checks++; if ({hi_out, lo_out} !== 64'h0) begin n_fail++; $display("FAIL madd_wrap got %h want 0", {hi_out, lo_out}); end
        m_acc = '0;
    endtask

    task automatic test_ignored_during_acc();
        logic [DW-1:0]   h;
        logic [DW-1:0]   l;
        logic [2*DW-1:0] r;
        h = $urandom;
        l = $urandom;
        r = m_acc + {h, l};
        do_op(3'd4, h, l);
        op_valid = 1'b1;
        op_mode  = 3'd2;
        lo_in    = 32'h55;
        hi_in    = $urandom;
        @(posedge clk); #1;
        n_checks++; if ({hi_out, lo_out} !== r) begin n_fail++; $display("FAIL stall_ignore got %h want %h", {hi_out, lo_out}, r); end
        n_checks++; if (acc_done !== 1'b1) begin n_fail++; $display("FAIL stall_done got %b want 1", acc_done); end
        @(posedge clk); #1;
        op_valid = 1'b0;
        n_checks++; if ({hi_out, lo_out} !== {r[2*DW-1:DW], 32'h55}) begin n_fail++; $display("FAIL stall_reissue got %h want %h", {hi_out, lo_out}, {r[2*DW-1:DW], 32'h55}); end
        m_acc = {r[2*DW-1:DW], 32'h55};
    endtask

    task automatic test_random_acc();
        logic [2:0]      mode;
        logic [DW-1:0]   h;
        logic [DW-1:0]   l;
        logic [2*DW-1:0] r;
        for (int i = 0; i < 30; i++) begin
            mode = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd5;
            h = (i < 5) ? 32'hFFFFFFFF : $urandom;
            l = (i < 5) ? 32'hFFFFFFFF : $urandom;
            r = (mode == 3'd4) ? (m_acc + {h, l}) : (m_acc - {h, l});
            do_op(mode, h, l);
            n_checks++; if ({hi_out, lo_out} !== {m_acc[2*DW-1:DW], r[DW-1:0]}) begin n_fail++; $display("FAIL racc_e1[%0d] got %h want %h", i, {hi_out, lo_out}, {m_acc[2*DW-1:DW], r[DW-1:0]}); end
            n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL racc_ready[%0d] got %b want 0", i, op_ready); end
            @(posedge clk); #1;
            n_checks++; if ({hi_out, lo_out} !== r) begin n_fail++; $display("FAIL racc_e2[%0d] got %h want %h", i, {hi_out, lo_out}, r); end
            n_checks++; if (acc_done !== 1'b1) begin n_fail++; $display("FAIL racc_done[%0d] got %b want 1", i, acc_done); end
            m_acc = r;
        end
    endtask
`else
    task automatic test_acc_disabled();
        for (int i = 0; i < 10; i++) begin
            do_op(($urandom_range(0, 1) == 0) ? 3'd4 : 3'd5, $urandom, $urandom);
            n_checks++; if ({hi_out, lo_out} !== m_acc) begin n_fail++; $display("FAIL noacc_hilo[%0d] got %h want %h", i, {hi_out, lo_out}, m_acc); end
            n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL noacc_ready[%0d] got %b want 1", i, op_ready); end
            n_checks++; if (acc_done !== 1'b0) begin n_fail++; $display("FAIL noacc_done[%0d] got %b want 0", i, acc_done); end
            n_checks++; if (hilo_stable !== 1'b1) begin n_fail++; $display("FAIL noacc_stable[%0d] got %b want 1", i, hilo_stable); end
        end
    endtask
`endif

    task automatic test_reset_mid_acc();
        do_op(3'd3, $urandom | 32'h1, $urandom | 32'h1);
        do_op(3'd4, $urandom, $urandom);
        #2;
        rst_n = 1'b0;
        #1;
        m_acc = '0;
        n_checks++; if ({hi_out, lo_out} !== m_acc) begin n_fail++; $display("FAIL midrst_hilo got %h want 0", {hi_out, lo_out}); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", op_ready); end
        n_checks++; if (hilo_stable !== 1'b1) begin n_fail++; $display("FAIL midrst_stable got %b want 1", hilo_stable); end
        @(posedge clk); #1;
        n_checks++; if (acc_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", acc_done); end
        rst_n = 1'b1;
        do_op(3'd2, $urandom, 32'h7);
        n_checks++; if ({hi_out, lo_out} !== {32'h0, 32'h7}) begin n_fail++; $display("FAIL postrst_wlo got %h want 7", {hi_out, lo_out}); end
        n_checks++; if (acc_done !== 1'b0) begin n_fail++; $display("FAIL postrst_done got %b want 0", acc_done); end
        m_acc = {32'h0, 32'h7};
    endtask

    initial begin
        test_reset();
        test_writes();
        test_back_to_back();
`ifdef HILO_ACC_EN
        test_madd_carry();
        test_msub_wrap();
        test_ignored_during_acc();
        test_random_acc();
`else
        test_acc_disabled();
`endif
        test_reset_mid_acc();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
